// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: WIDTH-bit operands, 2*WIDTH-bit product after WIDTH cycles.
// Signed operation multiplies magnitudes and applies the sign once at completion.
module seq_multiplier #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     in1,
  input  logic [WIDTH-1:0]     in2,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   out
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  // The most negative signed value maps to 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] value,
                                                 input logic             as_signed);
    if (as_signed && value[WIDTH-1]) begin
      return ~value + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      return value;
    end
  endfunction

  state_t                 state_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [WIDTH-1:0]       mag_a_r;
  logic [WIDTH-1:0]       mag_b_r;
  logic [2*WIDTH-1:0]     acc_r;
  logic                   neg_r;

  logic [WIDTH-1:0]       in_mag_a_s;
  logic [WIDTH-1:0]       in_mag_b_s;
  logic                   in_neg_s;
  logic [2*WIDTH-1:0]     partial_s;
  logic [2*WIDTH-1:0]     acc_next_s;
  logic [2*WIDTH-1:0]     result_s;
  logic                   last_s;

  // Operand conditioning at the accept edge.
  always_comb begin
    in_mag_a_s = magnitude(in1, is_signed);
    in_mag_b_s = magnitude(in2, is_signed);
    in_neg_s   = is_signed & (in1[WIDTH-1] ^ in2[WIDTH-1]);
  end

  // One shift-add step; the final step's sum feeds the signed result directly.
  always_comb begin
    partial_s  = {{WIDTH{1'b0}}, mag_a_r} << cnt_r;
    acc_next_s = acc_r;
    result_s   = acc_next_s;
    if (mag_b_r[0]) begin
      acc_next_s = acc_r + partial_s;
    end else begin
      acc_next_s = acc_r;
    end
    if (neg_r) begin
      result_s = ~acc_next_s + {{(2*WIDTH-1){1'b0}}, 1'b1};
    end else begin
      result_s = acc_next_s;
    end
    last_s = (cnt_r == LAST_CNT);
  end

  // Control FSM and datapath registers with registered status/product outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      mag_a_r <= {WIDTH{1'b0}};
      mag_b_r <= {WIDTH{1'b0}};
      acc_r   <= {(2*WIDTH){1'b0}};
      neg_r   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      out     <= {(2*WIDTH){1'b0}};
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            mag_a_r <= in_mag_a_s;
            mag_b_r <= in_mag_b_s;
            neg_r   <= in_neg_s;
            acc_r   <= {(2*WIDTH){1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            busy    <= 1'b1;
            state_r <= CALC;
          end
        end
        CALC: begin
          acc_r   <= acc_next_s;
          mag_b_r <= {1'b0, mag_b_r[WIDTH-1:1]};
          cnt_r   <= cnt_r + CNT_W'(1);
          if (last_s) begin
            out     <= result_s;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed WIDTH=32 scenarios plus randomised WIDTH=8 traffic.
module tb_seq_multiplier;

  logic        clk;
  logic        rst;
  logic        start32, sgn32;
  logic [31:0] a32, b32;
  logic        busy32, done32;
  logic [63:0] out32;
  logic        start8, sgn8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [15:0] out8;

  int          checks;
  int          errors;
  logic [63:0] exp_prev32;

  seq_multiplier #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .is_signed(sgn32),
    .in1(a32), .in2(b32), .busy(busy32), .done(done32), .out(out32)
  );

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .is_signed(sgn8),
    .in1(a8), .in2(b8), .busy(busy8), .done(done8), .out(out8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: sign/zero extend to the product width and multiply, keeping the low 2*WIDTH bits.
  function automatic logic [63:0] ref_mul32(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [63:0] ea, eb;
    ea = s ? {{32{a[31]}}, a} : {32'h0, a};
    eb = s ? {{32{b[31]}}, b} : {32'h0, b};
    return ea * eb;
  endfunction

  function automatic logic [15:0] ref_mul8(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic [15:0] ea, eb;
    ea = s ? {{8{a[7]}}, a} : {8'h0, a};
    eb = s ? {{8{b[7]}}, b} : {8'h0, b};
    return ea * eb;
  endfunction

  // Drive a start at the current negedge; returns one negedge after the accept edge.
  task automatic start32_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    start32 = 1'b1; a32 = a; b32 = b; sgn32 = s;
    @(negedge clk);
    start32 = 1'b0;
    checks++;
    if (busy32 !== 1'b1 || done32 !== 1'b0 || out32 !== exp_prev32) begin
      errors++;
      $display("FAIL accept: busy=%b done=%b out=%h, expected busy=1 done=0 out=%h",
               busy32, done32, out32, exp_prev32);
    end
  endtask

  // Follow an accepted operation to completion; optional noise on inputs while busy.
  task automatic wait32_done(input logic [63:0] exp, input bit noise, input string name);
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      checks++;
      if (busy32 !== 1'b1 || done32 !== 1'b0 || out32 !== exp_prev32) begin
        errors++;
        $display("FAIL %s calc cycle %0d: busy=%b done=%b out=%h, expected busy=1 done=0 out=%h",
                 name, i, busy32, done32, out32, exp_prev32);
      end
      if (noise) begin
        start32 = 1'($urandom);
        a32     = $urandom;
        b32     = $urandom;
        sgn32   = 1'($urandom);
      end
    end
    @(negedge clk);
    start32 = 1'b0;
    checks++;
    if (busy32 !== 1'b0 || done32 !== 1'b1 || out32 !== exp) begin
      errors++;
      $display("FAIL %s result: busy=%b done=%b out=%h, expected busy=0 done=1 out=%h",
               name, busy32, done32, out32, exp);
    end
    exp_prev32 = exp;
  endtask

  task automatic test_reset();
    rst = 1'b1; start32 = 1'b1; a32 = 32'd7; b32 = 32'd9; sgn32 = 1'b0;
    start8 = 1'b1; a8 = 8'd3; b8 = 8'd4; sgn8 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (busy32 !== 1'b0 || done32 !== 1'b0 || out32 !== 64'h0 ||
          busy8 !== 1'b0 || done8 !== 1'b0 || out8 !== 16'h0) begin
        errors++;
        $display("FAIL reset_hold: busy=%b done=%b out=%h busy8=%b done8=%b out8=%h, expected all 0",
                 busy32, done32, out32, busy8, done8, out8);
      end
    end
    rst = 1'b0; start32 = 1'b0; start8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (busy32 !== 1'b0 || done32 !== 1'b0 || out32 !== 64'h0 || busy8 !== 1'b0 || done8 !== 1'b0) begin
        errors++;
        $display("FAIL reset_release: busy=%b done=%b out=%h busy8=%b done8=%b, expected all 0",
                 busy32, done32, out32, busy8, done8);
      end
    end
    exp_prev32 = 64'h0;
  endtask

  task automatic test_unsigned_max();
    start32_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait32_done(64'hFFFF_FFFE_0000_0001, 1'b0, "unsigned_max");
    @(negedge clk);
    checks++;
    if (done32 !== 1'b0 || busy32 !== 1'b0 || out32 !== 64'hFFFF_FFFE_0000_0001) begin
      errors++;
      $display("FAIL done_pulse_width: done=%b busy=%b out=%h, expected done=0 busy=0 out held",
               done32, busy32, out32);
    end
  endtask

  task automatic test_signed_cases();
    start32_op(32'hFFFF_FFFD, 32'd7, 1'b1);
    wait32_done(64'hFFFF_FFFF_FFFF_FFEB, 1'b0, "signed_neg3x7");
    @(negedge clk);
    start32_op(32'h8000_0000, 32'h8000_0000, 1'b1);
    wait32_done(64'h4000_0000_0000_0000, 1'b0, "signed_minxmin");
    @(negedge clk);
    start32_op(32'h0, 32'hFFFF_FFFF, 1'b1);
    wait32_done(64'h0, 1'b0, "signed_zero");
    @(negedge clk);
    start32_op(32'h8000_0000, 32'd1, 1'b1);
    wait32_done(ref_mul32(32'h8000_0000, 32'd1, 1'b1), 1'b0, "signed_minx1");
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    start32_op(32'd1234567, 32'hFFFF_0000, 1'b0);
    wait32_done(ref_mul32(32'd1234567, 32'hFFFF_0000, 1'b0), 1'b0, "b2b_first");
    start32_op(32'd5, 32'd6, 1'b0);
    wait32_done(64'd30, 1'b0, "b2b_second");
    @(negedge clk);
  endtask

  task automatic test_ignore_during_calc();
    start32_op(32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
    wait32_done(ref_mul32(32'hDEAD_BEEF, 32'h1234_5678, 1'b1), 1'b1, "ignore_noise");
    @(negedge clk);
    checks++;
    if (busy32 !== 1'b0 || done32 !== 1'b0) begin
      errors++;
      $display("FAIL ignore_no_restart: busy=%b done=%b, expected busy=0 done=0", busy32, done32);
    end
  endtask

  task automatic test_abort();
    start32_op(32'd1000, 32'd3000, 1'b0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_prev32 = 64'h0;
    checks++;
    if (busy32 !== 1'b0 || done32 !== 1'b0 || out32 !== 64'h0) begin
      errors++;
      $display("FAIL abort_reset: busy=%b done=%b out=%h, expected 0 0 0", busy32, done32, out32);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if (done32 !== 1'b0 || busy32 !== 1'b0 || out32 !== 64'h0) begin
        errors++;
        $display("FAIL abort_quiet cycle %0d: busy=%b done=%b out=%h, expected 0 0 0",
                 i, busy32, done32, out32);
      end
    end
    start32_op(32'd9, 32'hFFFF_FFFE, 1'b1);
    wait32_done(64'hFFFF_FFFF_FFFF_FFEE, 1'b0, "after_abort");
    @(negedge clk);
  endtask

  // 1000 chained WIDTH=8 operations; each new start is issued in the previous done cycle.
  task automatic test_random_w8();
    logic [15:0] exp;
    int          cyc;
    a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = 1'($urandom);
    start8 = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      exp = ref_mul8(a8, b8, sgn8);
      @(negedge clk);
      start8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = 1'($urandom);
      cyc = 0;
      while (done8 !== 1'b1 && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      checks++;
      if (cyc != 8 || out8 !== exp) begin
        errors++;
        $display("FAIL w8_op %0d: done after %0d cycles out=%h, expected 8 cycles out=%h",
                 n, cyc, out8, exp);
      end
      if (n % 5 == 4) begin
        a8 = 8'h80; b8 = (n % 10 == 4) ? 8'h80 : 8'h00; sgn8 = 1'b1;
      end
      start8 = 1'b1;
    end
    start8 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    checks = 0; errors = 0; exp_prev32 = 64'h0;
    rst = 1'b1; start32 = 1'b0; sgn32 = 1'b0; a32 = 32'h0; b32 = 32'h0;
    start8 = 1'b0; sgn8 = 1'b0; a8 = 8'h0; b8 = 8'h0;
    test_reset();
    test_unsigned_max();
    test_signed_cases();
    test_back_to_back();
    test_ignore_during_calc();
    test_abort();
    test_random_w8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
